// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-writeback pipeline stage.
//
// Completes the data-cache handshake for loads and stores and holds upstream
// stages until the cache responds. Load data is aligned and extended here.
// The MEM/WB state is registered and drives the register-file write port,
// the forwarding path and a retired-instruction counter.
//
// Optional build macro: WB_TIMEOUT_EN. When defined, a watchdog counts the
// cycles spent in WAIT and sets a sticky timeout_err once MAX_WAIT is reached.
// The FSM keeps waiting after the watchdog fires. When it is undefined,
// timeout_err is tied to 0.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid             MEM-stage instruction valid
//   in_opcode/funct3/rd  instruction fields
//   in_alu_out           effective address / ALU result
//   in_rmask/in_wmask    byte masks (nonzero = load / store access)
//   in_result            writeback value for non-load instructions
//   data_mem_*           cache handshake (read/write strobes, rdata, resp)
//   stall_req            hold all upstream stages
//   fwd_*                forwarding source (mirrors registered write port)
//   wb_valid             instruction retired this cycle
//   regfile_*            register-file write port
//   instret              retired-instruction count
//   timeout_err          sticky watchdog flag
module mem_wb_stage #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_alu_out,
  input  logic [3:0]       in_rmask,
  input  logic [3:0]       in_wmask,
  input  logic [31:0]      in_result,
  input  logic [31:0]      data_mem_rdata,
  input  logic             data_mem_resp,
  output logic             data_mem_read,
  output logic             data_mem_write,
  output logic             stall_req,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [31:0]      fwd_data,
  output logic             wb_valid,
  output logic             regfile_we,
  output logic [4:0]       regfile_rd,
  output logic [31:0]      regfile_wdata,
  output logic [CNT_W-1:0] instret,
  output logic             timeout_err
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state_q, state_d;

  logic has_rd, has_wr, mem_op;
  logic is_load, is_store, is_branch;
  logic complete;

  assign has_rd    = in_rmask != 4'b0000;
  assign has_wr    = in_wmask != 4'b0000;
  assign mem_op    = in_valid & (has_rd | has_wr);
  assign is_load   = in_opcode == OpLoad;
  assign is_store  = in_opcode == OpStore;
  assign is_branch = in_opcode == OpBranch;

  // Non-memory instructions retire immediately; memory ones on the response.
  assign complete = in_valid & (~mem_op | data_mem_resp);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mem_op && !data_mem_resp) state_d = StWait;
      StWait: if (data_mem_resp)            state_d = StIdle;
      default:                              state_d = StIdle;
    endcase
  end

  // FSM: outputs. Strobes and stall are identical in both states; the state
  // only tracks an outstanding access (used by the watchdog).
  always_comb begin
    data_mem_read  = mem_op & has_rd;
    data_mem_write = mem_op & has_wr;
    stall_req      = mem_op & ~data_mem_resp;
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  logic [1:0]  off;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;

  assign off = in_alu_out[1:0];

  always_comb begin
    // off[0] is ignored for halfwords (misaligned halves are not supported).
    half_sel = off[1] ? data_mem_rdata[31:16] : data_mem_rdata[15:0];
    byte_sel = 8'h00;
    unique case (off)
      2'd0: byte_sel = data_mem_rdata[7:0];
      2'd1: byte_sel = data_mem_rdata[15:8];
      2'd2: byte_sel = data_mem_rdata[23:16];
      2'd3: byte_sel = data_mem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    case (in_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = data_mem_rdata;
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB registers
  // ---------------------------------------------------------------------------
  logic             wb_valid_q, regfile_we_q;
  logic [4:0]       regfile_rd_q;
  logic [31:0]      regfile_wdata_q;
  logic [CNT_W-1:0] instret_q;
  logic             we_d;

  assign we_d = ~is_store & ~is_branch & (in_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q      <= 1'b0;
      regfile_we_q    <= 1'b0;
      regfile_rd_q    <= 5'd0;
      regfile_wdata_q <= 32'h0;
    end else if (complete) begin
      wb_valid_q      <= 1'b1;
      regfile_we_q    <= we_d;
      regfile_rd_q    <= in_rd;
      regfile_wdata_q <= is_load ? load_data : in_result;
    end else begin
      // Index and data hold so forwarding consumers see stable values.
      wb_valid_q      <= 1'b0;
      regfile_we_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (wb_valid_q) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign regfile_we    = regfile_we_q;
  assign regfile_rd    = regfile_rd_q;
  assign regfile_wdata = regfile_wdata_q;
  assign instret       = instret_q;

  assign fwd_valid = regfile_we_q;
  assign fwd_rd    = regfile_rd_q;
  assign fwd_data  = regfile_wdata_q;

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef WB_TIMEOUT_EN
  localparam int unsigned WaitW =
      ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_inc;
  logic             timeout_q;

  // Saturate so a long wait never wraps back below the limit.
  assign wait_cnt_inc = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && state_d == StWait) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_inc;
        // Flag on the edge that ends the MAX_WAIT-th WAIT cycle.
        if (WaitW'(MAX_WAIT) <= wait_cnt_inc) timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;

  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
`endif

  logic unused_addr_hi;
  assign unused_addr_hi = ^in_alu_out[31:2];

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage (default build, watchdog disabled).
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked 1 unit later and registered outputs 1 unit after the following edge.
module tb_mem_wb_stage;

  localparam int unsigned CntW = 64;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic [4:0]      in_rd;
  logic [31:0]     in_alu_out;
  logic [3:0]      in_rmask;
  logic [3:0]      in_wmask;
  logic [31:0]     in_result;
  logic [31:0]     data_mem_rdata;
  logic            data_mem_resp;
  logic            data_mem_read;
  logic            data_mem_write;
  logic            stall_req;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [31:0]     fwd_data;
  logic            wb_valid;
  logic            regfile_we;
  logic [4:0]      regfile_rd;
  logic [31:0]     regfile_wdata;
  logic [CntW-1:0] instret;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;
  longint unsigned exp_instret = 0;

  mem_wb_stage #(
    .MAX_WAIT (255),
    .CNT_W    (CntW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_opcode      (in_opcode),
    .in_funct3      (in_funct3),
    .in_rd          (in_rd),
    .in_alu_out     (in_alu_out),
    .in_rmask       (in_rmask),
    .in_wmask       (in_wmask),
    .in_result      (in_result),
    .data_mem_rdata (data_mem_rdata),
    .data_mem_resp  (data_mem_resp),
    .data_mem_read  (data_mem_read),
    .data_mem_write (data_mem_write),
    .stall_req      (stall_req),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
    .wb_valid       (wb_valid),
    .regfile_we     (regfile_we),
    .regfile_rd     (regfile_rd),
    .regfile_wdata  (regfile_wdata),
    .instret        (instret),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] res, input logic [31:0] rdata,
                       input logic resp);
    in_valid       = v;
    in_opcode      = op;
    in_funct3      = f3;
    in_rd          = rd;
    in_alu_out     = alu;
    in_rmask       = rm;
    in_wmask       = wm;
    in_result      = res;
    data_mem_rdata = rdata;
    data_mem_resp  = resp;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 7'h0, 3'h0, 5'd0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Check the retire outputs of the instruction that completed on the last edge.
  task automatic check_retire(input string tag, input logic we, input logic [4:0] rd,
                              input logic [31:0] wdata, input logic chk_data);
    exp_instret++;
    check_eq({tag, ".wb_valid"}, {63'h0, wb_valid}, 64'h1);
    check_eq({tag, ".we"}, {63'h0, regfile_we}, {63'h0, we});
    check_eq({tag, ".fwd_valid"}, {63'h0, fwd_valid}, {63'h0, we});
    check_eq({tag, ".rd"}, {59'h0, regfile_rd}, {59'h0, rd});
    check_eq({tag, ".fwd_rd"}, {59'h0, fwd_rd}, {59'h0, rd});
    if (chk_data) begin
      check_eq({tag, ".wdata"}, {32'h0, regfile_wdata}, {32'h0, wdata});
      check_eq({tag, ".fwd_data"}, {32'h0, fwd_data}, {32'h0, wdata});
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check_eq("rst.wb_valid", {63'h0, wb_valid}, 64'h0);
    check_eq("rst.we", {63'h0, regfile_we}, 64'h0);
    check_eq("rst.rd", {59'h0, regfile_rd}, 64'h0);
    check_eq("rst.wdata", {32'h0, regfile_wdata}, 64'h0);
    check_eq("rst.instret", instret, 64'h0);
    check_eq("rst.timeout", {63'h0, timeout_err}, 64'h0);
    check_eq("rst.stall", {63'h0, stall_req}, 64'h0);
    tick();

    // add x5 -> 0x1234, no memory access
    drive(1'b1, 7'b0110011, 3'b000, 5'd5, 32'h0, 4'h0, 4'h0, 32'h1234, 32'h0, 1'b0);
    #1;
    check_eq("add.stall", {63'h0, stall_req}, 64'h0);
    check_eq("add.read", {63'h0, data_mem_read}, 64'h0);
    tick();
    idle_inputs();
    check_retire("add", 1'b1, 5'd5, 32'h1234, 1'b1);
    tick();
    check_eq("add.instret", instret, exp_instret);
    check_eq("idle.wb_valid", {63'h0, wb_valid}, 64'h0);
    check_eq("idle.we", {63'h0, regfile_we}, 64'h0);
    check_eq("idle.rd_hold", {59'h0, regfile_rd}, 64'd5);
    check_eq("idle.wdata_hold", {32'h0, regfile_wdata}, 64'h1234);

    // lb x6, offset 3, zero-wait hit
    drive(1'b1, 7'b0000011, 3'b000, 5'd6, 32'h103, 4'b1000, 4'h0, 32'h0, 32'h80FF_FF7F, 1'b1);
    #1;
    check_eq("lb.stall", {63'h0, stall_req}, 64'h0);
    check_eq("lb.read", {63'h0, data_mem_read}, 64'h1);
    check_eq("lb.write", {63'h0, data_mem_write}, 64'h0);
    tick();
    idle_inputs();
    check_retire("lb", 1'b1, 5'd6, 32'hFFFF_FF80, 1'b1);
    tick();
    check_eq("lb.instret", instret, exp_instret);

    // lhu x7, offset 2, response after 3 stall cycles
    drive(1'b1, 7'b0000011, 3'b101, 5'd7, 32'h102, 4'b1100, 4'h0, 32'h0, 32'hBEEF_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("lhu.stall%0d", i), {63'h0, stall_req}, 64'h1);
      check_eq($sformatf("lhu.read%0d", i), {63'h0, data_mem_read}, 64'h1);
      tick();
      check_eq($sformatf("lhu.nowb%0d", i), {63'h0, wb_valid}, 64'h0);
      check_eq($sformatf("lhu.rdhold%0d", i), {59'h0, regfile_rd}, 64'd6);
    end
    data_mem_resp = 1'b1;
    #1;
    check_eq("lhu.stall_end", {63'h0, stall_req}, 64'h0);
    check_eq("lhu.read_last", {63'h0, data_mem_read}, 64'h1);
    tick();
    idle_inputs();
    check_retire("lhu", 1'b1, 5'd7, 32'h0000_BEEF, 1'b1);
    tick();
    check_eq("lhu.instret", instret, exp_instret);

    // sw, response after 2 stall cycles
    drive(1'b1, 7'b0100011, 3'b010, 5'd9, 32'h200, 4'h0, 4'b1111, 32'hDEAD, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq($sformatf("sw.write%0d", i), {63'h0, data_mem_write}, 64'h1);
      check_eq($sformatf("sw.stall%0d", i), {63'h0, stall_req}, 64'h1);
      check_eq($sformatf("sw.read%0d", i), {63'h0, data_mem_read}, 64'h0);
      tick();
    end
    data_mem_resp = 1'b1;
    #1;
    check_eq("sw.write_last", {63'h0, data_mem_write}, 64'h1);
    check_eq("sw.stall_end", {63'h0, stall_req}, 64'h0);
    tick();
    idle_inputs();
    check_retire("sw", 1'b0, 5'd9, 32'h0, 1'b0);
    tick();
    check_eq("sw.instret", instret, exp_instret);

    // lw into x0: retires but never writes
    drive(1'b1, 7'b0000011, 3'b010, 5'd0, 32'h2, 4'b1111, 4'h0, 32'h0, 32'h1234_5678, 1'b1);
    tick();
    idle_inputs();
    check_retire("lw_x0", 1'b0, 5'd0, 32'h1234_5678, 1'b1);
    tick();
    check_eq("lw_x0.instret", instret, exp_instret);

    // Stray response with no memory op is ignored
    drive(1'b0, 7'b0000011, 3'b010, 5'd8, 32'h0, 4'b1111, 4'h0, 32'h0, 32'h0, 1'b1);
    #1;
    check_eq("stray.stall", {63'h0, stall_req}, 64'h0);
    check_eq("stray.read", {63'h0, data_mem_read}, 64'h0);
    tick();
    idle_inputs();
    check_eq("stray.wb_valid", {63'h0, wb_valid}, 64'h0);

    // lh x3, offset 1 (bit 0 ignored -> low half), negative
    drive(1'b1, 7'b0000011, 3'b001, 5'd3, 32'h1, 4'b0011, 4'h0, 32'h0, 32'h0000_8001, 1'b1);
    tick();
    idle_inputs();
    check_retire("lh", 1'b1, 5'd3, 32'hFFFF_8001, 1'b1);

    // lbu x4, offset 1
    drive(1'b1, 7'b0000011, 3'b100, 5'd4, 32'h101, 4'b0010, 4'h0, 32'h0, 32'h0000_A500, 1'b1);
    tick();
    idle_inputs();
    check_retire("lbu", 1'b1, 5'd4, 32'h0000_00A5, 1'b1);

    // Load with undefined funct3 gives 0
    drive(1'b1, 7'b0000011, 3'b011, 5'd10, 32'h0, 4'b1111, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    tick();
    idle_inputs();
    check_retire("ld_bad_f3", 1'b1, 5'd10, 32'h0, 1'b1);

    // Branch: retires, no register write
    drive(1'b1, 7'b1100011, 3'b000, 5'd11, 32'h0, 4'h0, 4'h0, 32'h55, 32'h0, 1'b0);
    tick();
    idle_inputs();
    check_retire("beq", 1'b0, 5'd11, 32'h55, 1'b1);
    tick();
    check_eq("beq.instret", instret, exp_instret);

    // Reset while waiting: access dropped, nothing retires, counters clear
    drive(1'b1, 7'b0000011, 3'b010, 5'd12, 32'h0, 4'b1111, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
    tick();
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    data_mem_resp = 1'b1;
    #1;
    check_eq("rstw.stall", {63'h0, stall_req}, 64'h0);
    check_eq("rstw.wb_valid", {63'h0, wb_valid}, 64'h0);
    check_eq("rstw.instret", instret, 64'h0);
    tick();
    idle_inputs();
    check_eq("rstw.no_retire", {63'h0, wb_valid}, 64'h0);
    check_eq("rstw.rd", {59'h0, regfile_rd}, 64'h0);
    tick();
    check_eq("rstw.instret2", instret, 64'h0);
    check_eq("end.timeout", {63'h0, timeout_err}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
